i2s_stereo_tx: RTL and testbench
================================

Name: i2s_stereo_tx

Overview:
- FPGA-side I2S clock-master transmitter that feeds stereo PCM samples into the SoC's I2S receive pads (sck, ws, sdi).
- Sits in the board wrapper beside the SoC instance and drives pad_i2s0_sck / pad_i2s0_ws / pad_i2s0_sdi.
- Gives the on-chip I2S receiver a deterministic audio source for bring-up and regression on the board.
- Samples arrive on a valid/ready stream and are serialised MSB-first in Philips I2S format (one-bit WS lead).

Parameters:
- DATA_WIDTH, 16, bits per channel sample; must be >= 2.
- CLK_DIV, 4, SCK half-period in clk_i cycles; must be >= 1. SCK frequency = f(clk_i) / (2*CLK_DIV).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, synchronous, active-high.
- en_i  in  1  transmit enable.
- s_left_i  in  DATA_WIDTH  left sample.
- s_right_i  in  DATA_WIDTH  right sample.
- s_valid_i  in  1  sample pair valid.
- s_ready_o  out  1  one-entry buffer empty; accepts the pair.
- i2s_sck_o  out  1  serial bit clock.
- i2s_ws_o  out  1  word select; 0 = left, 1 = right.
- i2s_sd_o  out  1  serial data.
- busy_o  out  1  high while in RUN.
- underrun_o  out  1  one-cycle pulse when a frame starts with an empty buffer.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high. Ports are clk_i and rst_i.
- Reset values: sck=0, ws=0, sd=0, busy=0, underrun=0, s_ready=1. Buffer is cleared, state = IDLE, divider = 0, bit index = 0.
- Buffer:
  - A pair is accepted when s_valid_i && s_ready_o; then buf_full=1.
  - s_ready_o = !buf_full, registered, with no bypass.
  - The buffer drains only at a frame load. Because of this, accept and drain can never coincide.
- IDLE -> RUN on en_i=1. This is the load cycle:
  - frame shift register <= {left, right} from the buffer, or all zeros with an underrun_o pulse if the buffer is empty.
  - buf_full <= 0.
  - sd_o <= left MSB, ws_o <= 0, divider <= 0, bit index b <= 0.
- RUN divider:
  - The divider counts 0..CLK_DIV-1.
  - At terminal count it toggles sck and resets to 0.
  - Rise event: sck 0->1. Fall event: sck 1->0.
- Data timing:
  - sd_o and ws_o change only at the load cycle or on fall events.
  - The receiver samples on rising SCK, so each bit is stable for one full SCK period around its rise.
- On each fall event ending bit b:
  - If b < 2*DATA_WIDTH-1: b <= b+1; sd_o <= next shift bit.
  - If b = 2*DATA_WIDTH-1 (frame end) and en_i=1: perform a frame load as above (b <= 0, new MSB, underrun check). There is no gap between frames.
  - If b = 2*DATA_WIDTH-1 (frame end) and en_i=0: go to IDLE; sck, ws, sd <= 0; busy <= 0.
- WS with one-bit lead: ws_o during bit b = (((b+1) mod 2*DATA_WIDTH) >= DATA_WIDTH).
  - WS rises during left LSB (b = DATA_WIDTH-1).
  - WS falls during right LSB (b = 2*DATA_WIDTH-1).
- Disable mid-frame: en_i is sampled only at frame end, so the current frame always completes.
- rst_i mid-frame: immediate return to reset values. No partial-frame completion and no underrun pulse.
- Frame latency: an accepted pair's first bit appears at the next frame load. Maximum wait is one frame = 2*DATA_WIDTH*2*CLK_DIV cycles.
- busy_o = 1 from the load cycle through the fall event that returns to IDLE.

Decomposition:
- Package i2s_stereo_tx_pkg holds the state enum (IDLE, RUN) and a localparam function for the frame length (2*DATA_WIDTH).
- Sub-module i2s_sck_gen: divider plus sck register. It outputs rise/fall strobes and has a synchronous clear used on IDLE entry and at reset.

Test Plan:
- DATA_WIDTH=16, CLK_DIV=2, push L=0xA5F0, R=0x0F0F, en_i=1 -> a rising-edge receiver model decodes L=0xA5F0, R=0x0F0F; ws rises on the 16th sck rise of the frame; no underrun.
- en_i=1 with no valid -> sd constant 0; underrun_o pulses once per frame (every 128 clk cycles); s_ready_o stays 1.
- Push 3 pairs back-to-back -> s_ready_o drops after each accept and rises the cycle after each frame load; decoded order is pair 0, 1, 2; no underrun until the buffer runs dry.
- Drop en_i at bit 5 of a frame -> the frame finishes all 32 bits, then sck/ws/sd=0 and busy_o=0; the buffered pair is retained and sent on re-enable.
- Assert rst_i at bit 20 -> next cycle all outputs are at reset values and s_ready_o=1; the buffered sample is lost.
- CLK_DIV=1, DATA_WIDTH=2 -> sck toggles every clk; ws sequence per bit is 0,1,1,0; sequential frames are contiguous.

Source files
------------

// File: rtl/i2s_stereo_tx_pkg.sv
// Shared constants for the I2S stereo transmitter: FSM encoding and frame sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   state_t / ST_IDLE / ST_RUN : top-level FSM encoding
//   frame_len()                : serial bits per stereo frame (left + right word)
package i2s_stereo_tx_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

  // One frame carries one left word followed by one right word.
  function automatic int frame_len(input int data_width);
    return 2 * data_width;
  endfunction

endpackage

// File: rtl/i2s_sck_gen.sv
// SCK divider: toggles the bit clock every CLK_DIV cycles of clk_i while running.
// Latency: rise/fall strobes are combinational and flag the edge on which sck_o changes.
// Backpressure: none; freezes at 0 while clr_i is high or run_i is low.
//
// Ports:
//   clk_i, rst_i : system clock, synchronous active-high reset
//   clr_i        : synchronous clear of divider and sck (held while the transmitter idles)
//   run_i        : count enable
//   sck_o        : registered bit clock
//   rise_o       : high in the cycle whose closing edge takes sck 0->1
//   fall_o       : high in the cycle whose closing edge takes sck 1->0
module i2s_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic run_i,
  output logic sck_o,
  output logic rise_o,
  output logic fall_o
);

  // A one-cycle half-period still needs a 1-bit counter so the terminal
  // compare has something to look at; it simply never leaves 0.
  localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIVW-1:0] DIV_TC = DIVW'(CLK_DIV - 1);

  logic [DIVW-1:0] div_q;
  logic            sck_q;
  logic            tc;

  assign tc     = run_i && (div_q == DIV_TC);
  assign rise_o = tc && !sck_q;
  assign fall_o = tc &&  sck_q;
  assign sck_o  = sck_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      div_q <= '0;
      sck_q <= 1'b0;
    end else if (run_i) begin
      if (div_q == DIV_TC) begin
        div_q <= '0;
        sck_q <= !sck_q;
      end else begin
        div_q <= div_q + DIVW'(1);
      end
    end
  end

endmodule

// File: rtl/i2s_stereo_tx.sv
// I2S clock-master transmitter: serialises stereo PCM pairs MSB-first, Philips format.
// Latency: an accepted pair starts at the next frame load, at most one frame later.
// Backpressure: s_ready_o drops while the one-entry buffer holds a pair; it frees at a frame load.
//
// Ports:
//   clk_i, rst_i          : system clock, synchronous active-high reset
//   en_i                  : transmit enable, sampled in IDLE and at each frame end
//   s_left_i, s_right_i   : sample pair, accepted on s_valid_i && s_ready_o
//   s_valid_i, s_ready_o  : stream handshake into the one-entry buffer
//   i2s_sck_o             : bit clock, f(clk_i) / (2*CLK_DIV)
//   i2s_ws_o              : word select (0 = left, 1 = right), one bit ahead of the data
//   i2s_sd_o              : serial data, changes on falling SCK only
//   busy_o                : high while a frame is in flight
//   underrun_o            : one-cycle pulse when a frame loads from an empty buffer
module i2s_stereo_tx
  import i2s_stereo_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] s_left_i,
  input  logic [DATA_WIDTH-1:0] s_right_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic                  i2s_sck_o,
  output logic                  i2s_ws_o,
  output logic                  i2s_sd_o,
  output logic                  busy_o,
  output logic                  underrun_o
);

  localparam int FRAME = frame_len(DATA_WIDTH);
  localparam int BW    = $clog2(FRAME);

  localparam logic [BW-1:0] LAST_BIT  = BW'(FRAME - 1);
  localparam logic [BW-1:0] LEFT_LSB  = BW'(DATA_WIDTH - 1);

  state_t                  state_q;
  logic                    buf_full_q;
  logic [DATA_WIDTH-1:0]   buf_left_q;
  logic [DATA_WIDTH-1:0]   buf_right_q;
  logic [FRAME-1:0]        shift_q;
  logic [BW-1:0]           bit_q;
  logic                    ws_q;
  logic                    underrun_q;

  logic                    sck;
  logic                    sck_rise;
  logic                    sck_fall;
  logic                    accept;
  logic                    frame_end;
  logic                    load;
  logic [BW-1:0]           bit_nxt;
  logic                    ws_nxt;

  i2s_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (state_q == ST_IDLE),
    .run_i  (state_q == ST_RUN),
    .sck_o  (sck),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  assign accept    = s_valid_i && !buf_full_q;
  assign frame_end = (state_q == ST_RUN) && sck_fall && (bit_q == LAST_BIT);

  // A frame loads either when leaving IDLE or back-to-back at the end of
  // the previous frame, so the bit stream stays contiguous.
  assign load = en_i && ((state_q == ST_IDLE) || frame_end);

  // WS leads the data by one bit: it goes high during the left LSB and
  // returns low during the right LSB. Only evaluated for bits 1..FRAME-1;
  // bit 0 always starts with WS low from the load.
  assign bit_nxt = bit_q + BW'(1);
  assign ws_nxt  = (bit_nxt >= LEFT_LSB) && (bit_nxt != LAST_BIT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      buf_full_q  <= 1'b0;
      buf_left_q  <= '0;
      buf_right_q <= '0;
      shift_q     <= '0;
      bit_q       <= '0;
      ws_q        <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      underrun_q <= 1'b0;

      // Accept has priority: it can only fire with the buffer empty, so a
      // coincident load reads an empty buffer and the new pair is kept.
      if (accept) begin
        buf_full_q  <= 1'b1;
        buf_left_q  <= s_left_i;
        buf_right_q <= s_right_i;
      end else if (load) begin
        buf_full_q  <= 1'b0;
      end

      if (load) begin
        state_q    <= ST_RUN;
        shift_q    <= buf_full_q ? {buf_left_q, buf_right_q} : '0;
        bit_q      <= '0;
        ws_q       <= 1'b0;
        underrun_q <= !buf_full_q;
      end else if ((state_q == ST_RUN) && sck_fall) begin
        if (bit_q == LAST_BIT) begin
          // Frame done with enable low: park everything at zero.
          state_q <= ST_IDLE;
          shift_q <= '0;
          bit_q   <= '0;
          ws_q    <= 1'b0;
        end else begin
          shift_q <= {shift_q[FRAME-2:0], 1'b0};
          bit_q   <= bit_nxt;
          ws_q    <= ws_nxt;
        end
      end
    end
  end

  assign s_ready_o  = !buf_full_q;
  assign i2s_sck_o  = sck;
  assign i2s_ws_o   = ws_q;
  assign i2s_sd_o   = shift_q[FRAME-1];
  assign busy_o     = (state_q == ST_RUN);
  assign underrun_o = underrun_q;

  // Data and WS only move on falling SCK; a load landing on a rising edge
  // would corrupt the bit the receiver is sampling.
  a_no_load_on_rise: assert property (@(posedge clk_i) disable iff (rst_i) !(sck_rise && load));

endmodule

// File: tb/tb_i2s_stereo_tx.sv
module tb_i2s_stereo_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, s_valid;
  logic [15:0] s_left, s_right;
  logic        sck, ws, sd, busy, underrun, s_ready;

  logic        b_en, b_valid;
  logic [1:0]  b_left, b_right;
  logic        b_sck, b_ws, b_sd, b_busy, b_underrun, b_ready;

  i2s_stereo_tx #(.DATA_WIDTH(16), .CLK_DIV(2)) dut_a (
    .clk_i(clk), .rst_i(rst), .en_i(en),
    .s_left_i(s_left), .s_right_i(s_right), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .i2s_sck_o(sck), .i2s_ws_o(ws), .i2s_sd_o(sd), .busy_o(busy), .underrun_o(underrun)
  );

  i2s_stereo_tx #(.DATA_WIDTH(2), .CLK_DIV(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .en_i(b_en),
    .s_left_i(b_left), .s_right_i(b_right), .s_valid_i(b_valid), .s_ready_o(b_ready),
    .i2s_sck_o(b_sck), .i2s_ws_o(b_ws), .i2s_sd_o(b_sd), .busy_o(b_busy), .underrun_o(b_underrun)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  logic sd_q[$];
  logic ws_q[$];
  logic prev_sck = 1'b0;
  int   urun_cnt = 0;

  // Advance one clock and sample 1 time unit after the edge; record the
  // rising-edge receiver view of dut_a.
  task automatic tick();
    @(posedge clk);
    #1;
    if (sck && !prev_sck) begin
      sd_q.push_back(sd);
      ws_q.push_back(ws);
    end
    prev_sck = sck;
    if (underrun) urun_cnt++;
  endtask

  function automatic logic [15:0] word_at(input int base);
    logic [15:0] w;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      if (base + i < sd_q.size()) w = {w[14:0], sd_q[base+i]};
      else                        w = {w[14:0], 1'b0};
    end
    return w;
  endfunction

  task automatic clear_capture();
    sd_q.delete();
    ws_q.delete();
    urun_cnt = 0;
  endtask

  task automatic go_idle(output logic ok);
    en = 1'b0;
    for (int i = 0; i < 400 && busy; i++) tick();
    ok = !busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; s_valid = 1'b0; s_left = '0; s_right = '0;
    b_en = 1'b0; b_valid = 1'b0; b_left = '0; b_right = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_checks++; if (sck !== 1'b0)      $display("FAIL reset_sck: got %b want 0", sck);           else n_pass++;
    n_checks++; if (ws !== 1'b0)       $display("FAIL reset_ws: got %b want 0", ws);             else n_pass++;
    n_checks++; if (sd !== 1'b0)       $display("FAIL reset_sd: got %b want 0", sd);             else n_pass++;
    n_checks++; if (busy !== 1'b0)     $display("FAIL reset_busy: got %b want 0", busy);         else n_pass++;
    n_checks++; if (underrun !== 1'b0) $display("FAIL reset_underrun: got %b want 0", underrun); else n_pass++;
    n_checks++; if (s_ready !== 1'b1)  $display("FAIL reset_ready: got %b want 1", s_ready);     else n_pass++;
  endtask

  task automatic test_single_pair();
    logic [31:0] wv;
    s_left = 16'hA5F0; s_right = 16'h0F0F; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    n_checks++; if (s_ready !== 1'b0) $display("FAIL single_ready_after_accept: got %b want 0", s_ready); else n_pass++;
    clear_capture();
    en = 1'b1;
    for (int i = 0; i < 400 && ws_q.size() < 32; i++) tick();
    n_checks++; if (ws_q.size() != 32) $display("FAIL single_rises: got %0d want 32", ws_q.size()); else n_pass++;
    n_checks++; if (word_at(0) !== 16'hA5F0)  $display("FAIL single_left: got %h want a5f0", word_at(0));   else n_pass++;
    n_checks++; if (word_at(16) !== 16'h0F0F) $display("FAIL single_right: got %h want 0f0f", word_at(16)); else n_pass++;
    wv = '0;
    for (int k = 0; k < 32 && k < ws_q.size(); k++) wv[k] = ws_q[k];
    n_checks++; if (wv[15:14] !== 2'b10) $display("FAIL single_ws_rise16: got %b want 10", wv[15:14]); else n_pass++;
    n_checks++; if (wv !== 32'h7FFF8000)  $display("FAIL single_ws_pattern: got %h want 7fff8000", wv); else n_pass++;
    n_checks++; if (urun_cnt != 0) $display("FAIL single_underrun: got %0d want 0", urun_cnt); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else n_pass++;
  endtask

  task automatic test_underrun();
    int n_pulse, p0, p1, sd_bad, rdy_bad;
    n_pulse = 0; p0 = -1; p1 = -1; sd_bad = 0; rdy_bad = 0;
    for (int i = 0; i < 200 && !underrun; i++) tick();
    n_checks++; if (underrun !== 1'b1) $display("FAIL underrun_first: got %b want 1", underrun); else n_pass++;
    for (int i = 1; i <= 256; i++) begin
      tick();
      if (underrun) begin
        if (n_pulse == 0) p0 = i; else if (n_pulse == 1) p1 = i;
        n_pulse++;
      end
      if (sd !== 1'b0) sd_bad++;
      if (s_ready !== 1'b1) rdy_bad++;
    end
    n_checks++; if (n_pulse != 2) $display("FAIL underrun_count: got %0d want 2", n_pulse); else n_pass++;
    n_checks++; if (p0 != 128 || p1 != 256) $display("FAIL underrun_period: got %0d,%0d want 128,256", p0, p1); else n_pass++;
    n_checks++; if (sd_bad != 0)  $display("FAIL underrun_sd: got %0d nonzero cycles want 0", sd_bad); else n_pass++;
    n_checks++; if (rdy_bad != 0) $display("FAIL underrun_ready: got %0d low cycles want 0", rdy_bad); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] pl [3];
    logic [15:0] pr [3];
    logic ok, acc, urun_384;
    int idx, rdy_err, early_urun;
    pl[0] = 16'h1357; pr[0] = 16'h2468;
    pl[1] = 16'hFFFF; pr[1] = 16'h0000;
    pl[2] = 16'h8001; pr[2] = 16'h7FFE;
    go_idle(ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL b2b_idle: got busy %b want 0", busy); else n_pass++;
    s_left = pl[0]; s_right = pr[0]; s_valid = 1'b1;
    tick();
    idx = 1; s_left = pl[1]; s_right = pr[1];
    rdy_err = 0; early_urun = 0; urun_384 = 1'b0;
    clear_capture();
    en = 1'b1;
    for (int t = 0; t <= 385; t++) begin
      acc = s_valid && s_ready;
      tick();
      if (acc) begin
        if (s_ready !== 1'b0) rdy_err++;
        idx++;
        if (idx < 3) begin s_left = pl[idx]; s_right = pr[idx]; end
        else s_valid = 1'b0;
      end
      if ((t == 0 || t == 128 || t == 256) && s_ready !== 1'b1) rdy_err++;
      if (t < 384 && underrun) early_urun++;
      if (t == 384) urun_384 = underrun;
    end
    n_checks++; if (rdy_err != 0) $display("FAIL b2b_ready_timing: got %0d errors want 0", rdy_err); else n_pass++;
    n_checks++; if (idx != 3) $display("FAIL b2b_accepts: got %0d want 3", idx); else n_pass++;
    n_checks++; if (sd_q.size() != 96) $display("FAIL b2b_rises: got %0d want 96", sd_q.size()); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({word_at(32*k), word_at(32*k+16)} !== {pl[k], pr[k]})
        $display("FAIL b2b_pair%0d: got %h_%h want %h_%h", k, word_at(32*k), word_at(32*k+16), pl[k], pr[k]);
      else n_pass++;
    end
    n_checks++; if (early_urun != 0)  $display("FAIL b2b_early_underrun: got %0d want 0", early_urun); else n_pass++;
    n_checks++; if (urun_384 !== 1'b1) $display("FAIL b2b_dry_underrun: got %b want 1", urun_384); else n_pass++;
  endtask

  task automatic test_disable_midframe();
    logic ok;
    int sck_bad;
    go_idle(ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL dis_idle: got busy %b want 0", busy); else n_pass++;
    s_left = 16'hC3A5; s_right = 16'h5A3C; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    clear_capture();
    en = 1'b1;
    tick();
    s_left = 16'h0FF0; s_right = 16'hF00F; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    for (int i = 0; i < 100 && ws_q.size() < 6; i++) tick();
    en = 1'b0;
    for (int i = 0; i < 400 && busy; i++) tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL dis_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (ws_q.size() != 32) $display("FAIL dis_rises: got %0d want 32", ws_q.size()); else n_pass++;
    n_checks++;
    if ({word_at(0), word_at(16)} !== 32'hC3A5_5A3C) $display("FAIL dis_pair: got %h_%h want c3a5_5a3c", word_at(0), word_at(16));
    else n_pass++;
    n_checks++; if ({sck, ws, sd} !== 3'b000) $display("FAIL dis_lines: got %b want 000", {sck, ws, sd}); else n_pass++;
    n_checks++; if (s_ready !== 1'b0) $display("FAIL dis_retained: got ready %b want 0", s_ready); else n_pass++;
    sck_bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sck !== 1'b0 || busy !== 1'b0) sck_bad++;
    end
    n_checks++; if (sck_bad != 0) $display("FAIL dis_quiet: got %0d active cycles want 0", sck_bad); else n_pass++;
    clear_capture();
    en = 1'b1;
    for (int i = 0; i < 400 && ws_q.size() < 32; i++) tick();
    go_idle(ok);
    n_checks++;
    if ({word_at(0), word_at(16)} !== 32'h0FF0_F00F) $display("FAIL dis_resend: got %h_%h want 0ff0_f00f", word_at(0), word_at(16));
    else n_pass++;
    n_checks++; if (urun_cnt != 0 || ok !== 1'b1) $display("FAIL dis_resend_clean: got underruns %0d idle %b want 0 1", urun_cnt, ok); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    logic ok;
    s_left = 16'h1111; s_right = 16'h2222; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    clear_capture();
    en = 1'b1;
    tick();
    s_left = 16'h8888; s_right = 16'h9999; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    for (int i = 0; i < 300 && ws_q.size() < 21; i++) tick();
    n_checks++; if (ws_q.size() != 21) $display("FAIL rst_reach_bit20: got %0d want 21", ws_q.size()); else n_pass++;
    rst = 1'b1; en = 1'b0;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({sck, ws, sd, busy, underrun, s_ready} !== 6'b000001)
      $display("FAIL rst_outputs: got %b want 000001", {sck, ws, sd, busy, underrun, s_ready});
    else n_pass++;
    en = 1'b1;
    tick();
    n_checks++; if ({underrun, sd, busy} !== 3'b101) $display("FAIL rst_buffer_lost: got %b want 101", {underrun, sd, busy}); else n_pass++;
    go_idle(ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL rst_idle: got busy %b want 0", busy); else n_pass++;
  endtask

  task automatic test_min_config();
    logic acc, prev_b;
    logic [7:0] sdv, wsv;
    int n_rise, tog_err, gap_err, b_urun;
    b_left = 2'b10; b_right = 2'b01; b_valid = 1'b1;
    tick();
    b_left = 2'b01; b_right = 2'b11; b_valid = 1'b1;
    b_en = 1'b1;
    prev_b = b_sck;
    n_rise = 0; tog_err = 0; gap_err = 0; b_urun = 0; sdv = '0; wsv = '0;
    for (int t = 0; t <= 16; t++) begin
      acc = b_valid && b_ready;
      tick();
      if (acc) b_valid = 1'b0;
      if (t == 10) b_en = 1'b0;
      if (t > 0 && b_sck === prev_b) tog_err++;
      if (b_sck && !prev_b) begin
        if (t != 2*n_rise + 1) gap_err++;
        if (n_rise < 8) begin sdv[n_rise] = b_sd; wsv[n_rise] = b_ws; end
        n_rise++;
      end
      if (b_underrun) b_urun++;
      prev_b = b_sck;
    end
    n_checks++; if (n_rise != 8)   $display("FAIL min_rises: got %0d want 8", n_rise); else n_pass++;
    n_checks++; if (tog_err != 0)  $display("FAIL min_sck_toggle: got %0d stalls want 0", tog_err); else n_pass++;
    n_checks++; if (gap_err != 0)  $display("FAIL min_contiguous: got %0d gaps want 0", gap_err); else n_pass++;
    n_checks++; if (wsv !== 8'h66) $display("FAIL min_ws_seq: got %b want 01100110", wsv); else n_pass++;
    n_checks++; if (sdv !== 8'hE9) $display("FAIL min_sd_seq: got %b want 11101001", sdv); else n_pass++;
    n_checks++; if (b_urun != 0)   $display("FAIL min_underrun: got %0d want 0", b_urun); else n_pass++;
    n_checks++; if ({b_busy, b_sck} !== 2'b00) $display("FAIL min_idle: got %b want 00", {b_busy, b_sck}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_pair();
    test_underrun();
    test_back_to_back();
    test_disable_midframe();
    test_reset_midframe();
    test_min_config();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation timeout");
  end

endmodule
